// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO: captures Receiver strobes, rejects 2-bit-error
// bytes, and presents a first-word-fall-through valid/ready output.
module rx_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clock,
   input  logic                     reset_L,
   input  logic [WIDTH-1:0]         messageByte,
   input  logic                     isNew,
   input  logic                     is2bitErr,
   output logic [WIDTH-1:0]         outByte,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [CNT_W-1:0]         dropCount,
   output logic [CNT_W-1:0]         errCount,
   input  logic                     clearStatus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_PTR = AW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rdPtr;
   logic [AW-1:0]    wrPtr;
   logic             goodStrobe;
   logic             push;
   logic             pop;
   logic             dropEvent;
   logic             errEvent;

   assign full       = (count == FULL_CNT);
   assign outValid   = (count != '0);
   assign pop        = outValid & outReady;
   assign goodStrobe = isNew & ~is2bitErr;
   assign push       = goodStrobe & (~full | pop);
   assign dropEvent  = goodStrobe & full & ~pop;
   assign errEvent   = isNew & is2bitErr;

   // Gated so the head reads zero whenever nothing is buffered.
   assign outByte = outValid ? mem[rdPtr] : '0;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wrPtr] <= messageByte;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + ONE_PTR;
         end
         if (pop) begin
            rdPtr <= rdPtr + ONE_PTR;
         end
         if (push && !pop) begin
            count <= count + ONE_CNT;
         end else if (pop && !push) begin
            count <= count - ONE_CNT;
         end
      end
   end

   // A clear in the same cycle as an event takes priority over the event.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         overflow  <= 1'b0;
         dropCount <= '0;
         errCount  <= '0;
      end else if (clearStatus) begin
         overflow  <= 1'b0;
         dropCount <= '0;
         errCount  <= '0;
      end else begin
         if (dropEvent) begin
            overflow <= 1'b1;
            if (dropCount != CNT_MAX) begin
               dropCount <= dropCount + CNT_ONE;
            end
         end
         if (errEvent && errCount != CNT_MAX) begin
            errCount <= errCount + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: vector table plus
// multi-cycle sequences for fill, overflow, wrap and reset.
module tb_rx_byte_fifo;

   logic       clock;
   logic       reset_L;
   logic [7:0] messageByte;
   logic       isNew;
   logic       is2bitErr;
   logic [7:0] outByte;
   logic       outValid;
   logic       outReady;
   logic [3:0] count;
   logic       full;
   logic       overflow;
   logic [7:0] dropCount;
   logic [7:0] errCount;
   logic       clearStatus;

   int total;
   int passed;

   rx_byte_fifo #(.DEPTH(8), .WIDTH(8), .CNT_W(8)) dut (
      .clock(clock),
      .reset_L(reset_L),
      .messageByte(messageByte),
      .isNew(isNew),
      .is2bitErr(is2bitErr),
      .outByte(outByte),
      .outValid(outValid),
      .outReady(outReady),
      .count(count),
      .full(full),
      .overflow(overflow),
      .dropCount(dropCount),
      .errCount(errCount),
      .clearStatus(clearStatus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       nw;
      logic       er;
      logic [7:0] msg;
      logic       rdy;
      logic       clr;
      logic       ov;
      logic [7:0] ob;
      logic [3:0] cnt;
      logic       fl;
      logic       ovf;
      logic [7:0] drp;
      logic [7:0] erc;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic nw, input logic er, input logic [7:0] m,
                        input logic rdy, input logic clr);
      isNew       = nw;
      is2bitErr   = er;
      messageByte = m;
      outReady    = rdy;
      clearStatus = clr;
   endtask

   function automatic logic [31:0] snap();
      return {1'b0, outValid, outByte, count, full, overflow,
              dropCount, errCount};
   endfunction

   initial begin
      logic [31:0] want;
      logic [7:0]  expB;
      total  = 0;
      passed = 0;
      reset_L = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      vecs[0]  = '{1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0};
      vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};
      vecs[2]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd1};
      vecs[3]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 4'd1, 1'b0, 1'b0, 8'd0, 8'd1};
      vecs[4]  = '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h33, 4'd1, 1'b0, 1'b0, 8'd0, 8'd1};
      vecs[5]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 4'd1, 1'b0, 1'b0, 8'd0, 8'd1};
      vecs[6]  = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 8'h44, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};
      vecs[8]  = '{1'b1, 1'b0, 8'h50, 1'b1, 1'b0, 1'b1, 8'h50, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};
      vecs[10] = '{1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd1};
      vecs[11] = '{1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd2};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0};

      step();
      step();
      chk("reset_state", snap(), 32'h0);
      reset_L = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].nw, vecs[i].er, vecs[i].msg, vecs[i].rdy, vecs[i].clr);
         step();
         want = {1'b0, vecs[i].ov, vecs[i].ob, vecs[i].cnt, vecs[i].fl,
                 vecs[i].ovf, vecs[i].drp, vecs[i].erc};
         chk($sformatf("vec%0d", i), snap(), want);
      end

      // Fill then drain in order
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("fill_full", {27'd0, full, count}, {27'd0, 1'b1, 4'd8});
      outReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d", i), {23'd0, outValid, outByte},
             {23'd0, 1'b1, 8'(i)});
         step();
      end
      chk("drain_empty", {27'd0, outValid, count}, 32'd0);

      // Refill, then overflow with saturation
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
      step();
      chk("ovf_first", {15'd0, overflow, dropCount, count, outByte[3:0]},
          {15'd0, 1'b1, 8'd1, 4'd8, 4'h0});
      for (int i = 1; i < 300; i++) step();
      chk("ovf_sat", {15'd0, overflow, dropCount, count, outByte[3:0]},
          {15'd0, 1'b1, 8'd255, 4'd8, 4'h0});
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step();
      chk("clear", {15'd0, overflow, dropCount, count, full, 3'd0},
          {15'd0, 1'b0, 8'd0, 4'd8, 1'b1, 3'd0});

      // Full with simultaneous push and pop
      drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
      step();
      chk("full_pushpop", {19'd0, overflow, count, outByte},
          {19'd0, 1'b0, 4'd8, 8'h11});
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         expB = (i == 8) ? 8'h55 : 8'h10 + 8'(i);
         chk($sformatf("pp_out%0d", i), {23'd0, outValid, outByte},
             {23'd0, 1'b1, expB});
         step();
      end
      chk("pp_empty", {27'd0, outValid, count}, 32'd0);

      // Set overflow again, then drain, so reset has something to clear
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step();
      chk("ovf_kept", {27'd0, overflow, count}, {27'd0, 1'b1, 4'd0});

      // Streaming one-in one-out across pointer wrap
      drive(1'b1, 1'b0, 8'h80, 1'b1, 1'b0);
      step();
      for (int i = 1; i < 20; i++) begin
         chk($sformatf("wrap%0d", i), {19'd0, outValid, count, outByte},
             {19'd0, 1'b1, 4'd1, 8'h80 + 8'(i - 1)});
         drive(1'b1, 1'b0, 8'h80 + 8'(i), 1'b1, 1'b0);
         step();
      end
      chk("wrap_last", {19'd0, outValid, count, outByte},
          {19'd0, 1'b1, 4'd1, 8'h93});

      // Asynchronous reset mid-stream
      drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      #2;
      reset_L = 1'b0;
      #1;
      chk("async_reset", {26'd0, outValid, count, overflow},
          {26'd0, 1'b0, 4'd0, 1'b0});
      step();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      reset_L = 1'b1;
      step();
      chk("post_reset", snap(), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
- Sits directly downstream of the serial Receiver.
- Captures each byte the Receiver flags with its one-cycle isNew strobe. Bytes marked with an uncorrectable (2-bit) error are discarded instead of captured.
- Buffers captured bytes in a first-word-fall-through FIFO and hands them to the consumer over a valid/ready handshake.
- Keeps sticky overflow status and saturating counters for dropped and errored bytes.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- WIDTH, 8, byte width; matches Receiver messageByte.
- CNT_W, 8, width of the drop and error counters.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_L  in  1  asynchronous active-low reset.
- messageByte  in  WIDTH  byte from the Receiver; valid only while isNew=1.
- isNew  in  1  one-cycle strobe: messageByte holds a new byte.
- is2bitErr  in  1  qualifies isNew; 1 means the byte is uncorrectable.
- outByte  out  WIDTH  head-of-FIFO byte; valid when outValid=1.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  consumer accepts outByte this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a good byte was dropped because the FIFO was full.
- dropCount  out  CNT_W  good bytes dropped while full; saturating.
- errCount  out  CNT_W  strobes rejected for is2bitErr; saturating.
- clearStatus  in  1  synchronous clear of overflow, dropCount and errCount.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - Read and write pointers = 0, count = 0.
  - outValid = 0, full = 0, overflow = 0, dropCount = 0, errCount = 0.
  - outByte = 0; memory contents don't-care.
- Release of reset is sampled synchronously; the first operation can happen on the first rising edge with reset_L=1.
- Push condition:
  - push = isNew & ~is2bitErr & (~full | pop).
  - On push, messageByte is written at the write pointer and the write pointer increments modulo DEPTH.
- Pop condition:
  - pop = outValid & outReady.
  - On pop, the read pointer increments modulo DEPTH.
  - outReady while outValid=0 has no effect.
- Both pointers wrap silently at DEPTH-1 -> 0.
- count is +1 on push only, -1 on pop only, and unchanged on push+pop or on neither.
- First-word-fall-through:
  - outByte = mem[read pointer], driven combinationally from registered state.
  - outValid = (count != 0).
  - A byte pushed at edge N is visible as outValid=1 / outByte after edge N; latency is 1 cycle.
  - A push into an empty FIFO is never popped in the same cycle.
- Full with a simultaneous pop: the incoming byte is accepted; count stays at DEPTH and nothing is dropped.
- Full without a pop, isNew=1 and is2bitErr=0:
  - The byte is dropped.
  - overflow is set to 1.
  - dropCount increments, saturating at 2^CNT_W-1.
- isNew=1 and is2bitErr=1:
  - The byte is never written, regardless of fullness.
  - errCount increments, saturating.
  - overflow is not affected.
- is2bitErr and messageByte are ignored whenever isNew=0.
- clearStatus=1:
  - On the next edge, overflow, dropCount and errCount become 0.
  - If a drop or error event occurs in the same cycle, the clear wins; the event is not counted.
  - FIFO contents are untouched.
- isNew held high for several consecutive cycles is treated as one byte per cycle; there is no edge detection.
- Reset asserted mid-operation discards all buffered data immediately. outValid goes to 0 without waiting for a clock edge.
- No combinational path from messageByte/isNew to outByte/outValid.
- Recommended state: one valid bit per pointer using an extra MSB wrap bit, or an equivalent count register.

Test Plan:
- Reset then single byte: isNew=1, messageByte=8'h41 for one cycle -> next cycle outValid=1, outByte=8'h41, count=1. outReady=1 for one cycle -> outValid=0, count=0.
- Fill and order: push 8'h00..8'h07 on consecutive cycles with outReady=0 -> full=1, count=8. Then hold outReady=1 -> outByte reads 00..07 in order, then outValid=0.
- Overflow: with the FIFO full, push 8'hAA with no pop -> byte dropped, overflow=1, dropCount=1, FIFO contents unchanged. Repeat 300 times with CNT_W=8 -> dropCount=255. Assert clearStatus -> overflow=0, dropCount=0.
- Full with simultaneous push+pop: with the FIFO full, isNew=1, messageByte=8'h55, outReady=1 -> count stays 8, overflow=0, and 8'h55 emerges as the 8th subsequent byte.
- Error rejection: isNew=1, is2bitErr=1, messageByte=8'hFF -> count unchanged, errCount=1. Next strobe with is2bitErr=0, messageByte=8'h33 -> stored normally.
- Wrap-around and reset: push/pop 20 bytes continuously at 1 per cycle with count held at 1 -> bytes read in order across the pointer wrap. Then assert reset_L=0 mid-stream -> outValid=0, count=0, overflow=0 immediately, before the next clock edge.
